// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, controller state encoding and a single-bit CRC step helper.
// Used by crc32_serial_lfsr (register update) and crc32_frame_ctrl (end-of-frame value
// when no FCS is appended).
package crc_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STALL = 2'd2,
    ST_FCS   = 2'd3
  } state_t;

  // One LSB-first step of the reflected CRC register.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic b,
                                             input logic [31:0] poly);
    crc32_step = (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? poly : 32'h0);
  endfunction
endpackage

// File: rtl/crc32_serial_lfsr.sv
// Bit-serial reflected CRC-32 register.
//  clk, res : clock, async active-high reset (register -> INIT)
//  init     : load INIT (wins over step)
//  step     : shift in bit_in this cycle
//  crc      : current register value
module crc32_serial_lfsr
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY_REFL,
  parameter logic [31:0] INIT = CRC32_INIT
) (
  input  logic        clk,
  input  logic        res,
  input  logic        init,
  input  logic        step,
  input  logic        bit_in,
  output logic [31:0] crc
);
  always_ff @(posedge clk or posedge res) begin
    if (res)       crc <= INIT;
    else if (init) crc <= INIT;
    else if (step) crc <= crc32_step(crc, bit_in, POLY);
  end
endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for the bit-serial CRC-32 datapath. Takes bytes over valid/ready,
// shifts each out LSB-first (one bit per clk) while feeding the CRC register, then
// optionally sends the 32-bit FCS LSB-first.
//  clk/res            : clock, async active-high reset
//  abort              : sync frame drop, back to IDLE next cycle (crc_out kept)
//  s_data/s_valid/s_last/s_ready : byte input handshake
//  tx_bit/tx_valid/tx_fcs/tx_eof : serial output, FCS flag, last bit of frame
//  busy               : state != IDLE
//  crc_out/crc_done   : final CRC (post XOR_OUT) and its one-cycle update pulse
// All outputs decode only registered state, so none depends combinationally on inputs.
module crc32_frame_ctrl
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY       = CRC32_POLY_REFL,
  parameter logic [31:0] INIT       = CRC32_INIT,
  parameter logic [31:0] XOR_OUT    = CRC32_XOR_OUT,
  parameter bit          APPEND_FCS = 1'b1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_fcs,
  output logic        tx_eof,
  output logic        busy,
  output logic [31:0] crc_out,
  output logic        crc_done
);
  state_t      state;
  logic [7:0]  shreg;
  logic        last_q;
  logic [2:0]  bit_cnt;
  logic [4:0]  fcs_cnt;
  logic        eof_q;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        lfsr_init;
  logic        lfsr_step;

  // CRC is frozen during FCS, so the FCS word can be read straight off the register.
  assign fcs       = crc ^ XOR_OUT;
  assign lfsr_init = abort | (state == ST_IDLE && s_valid);
  assign lfsr_step = (state == ST_DATA);

  crc32_serial_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk(clk), .res(res), .init(lfsr_init), .step(lfsr_step),
    .bit_in(shreg[0]), .crc(crc)
  );

  assign s_ready  = (state == ST_IDLE) || (state == ST_STALL) ||
                    (state == ST_DATA && bit_cnt == 3'd7 && !last_q);
  assign busy     = (state != ST_IDLE);
  assign tx_valid = (state == ST_DATA) || (state == ST_FCS);
  assign tx_fcs   = (state == ST_FCS);
  assign tx_bit   = (state == ST_DATA) ? shreg[0] :
                    (state == ST_FCS)  ? fcs[fcs_cnt] : 1'b0;
  assign tx_eof   = eof_q;
  assign crc_done = eof_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_IDLE;
      shreg   <= 8'h00;
      last_q  <= 1'b0;
      bit_cnt <= 3'd0;
      fcs_cnt <= 5'd0;
      eof_q   <= 1'b0;
      crc_out <= 32'h0;
    end else if (abort) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      fcs_cnt <= 5'd0;
      eof_q   <= 1'b0;
    end else begin
      eof_q <= 1'b0;
      case (state)
        ST_IDLE, ST_STALL: begin
          if (s_valid) begin
            shreg   <= s_data;
            last_q  <= s_last;
            bit_cnt <= 3'd0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          // Without FCS the last data bit is the eof cycle; its CRC is not in the
          // register yet, so fold the two remaining bits in ahead of time.
          if (!APPEND_FCS && last_q && bit_cnt == 3'd6) begin
            eof_q   <= 1'b1;
            crc_out <= crc32_step(crc32_step(crc, shreg[0], POLY), shreg[1], POLY) ^ XOR_OUT;
          end
          if (bit_cnt == 3'd7) begin
            if (last_q) begin
              fcs_cnt <= 5'd0;
              state   <= APPEND_FCS ? ST_FCS : ST_IDLE;
            end else if (s_valid) begin
              shreg  <= s_data;
              last_q <= s_last;
            end else begin
              state <= ST_STALL;
            end
          end
        end
        ST_FCS: begin
          fcs_cnt <= fcs_cnt + 5'd1;
          if (fcs_cnt == 5'd30) begin
            eof_q   <= 1'b1;
            crc_out <= fcs;
          end
          if (fcs_cnt == 5'd31) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Self-checking bench for crc32_frame_ctrl: table of known CRC-32 frames, random frames
// with random inter-byte stalls against a byte-wise CRC model, abort, a no-FCS instance,
// and asynchronous reset during FCS.
module tb_crc32_frame_ctrl;
  localparam logic [31:0] P = 32'hEDB88320;

  typedef logic [7:0] frame_t [0:15];
  typedef int dly_t [0:15];
  typedef struct { frame_t d; int n; logic [31:0] crc; } vec_t;

  logic clk = 1'b0, res = 1'b1;
  always #5 clk = ~clk;

  logic abort = 0, s_valid = 0, s_last = 0;
  logic [7:0] s_data = 0;
  logic s_ready, tx_bit, tx_valid, tx_fcs, tx_eof, busy, crc_done;
  logic [31:0] crc_out;

  logic abort0 = 0, s_valid0 = 0, s_last0 = 0;
  logic [7:0] s_data0 = 0;
  logic s_ready0, tx_bit0, tx_valid0, tx_fcs0, tx_eof0, busy0, crc_done0;
  logic [31:0] crc_out0;

  crc32_frame_ctrl dut (
    .clk(clk), .res(res), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_fcs(tx_fcs), .tx_eof(tx_eof), .busy(busy), .crc_out(crc_out), .crc_done(crc_done));

  crc32_frame_ctrl #(.APPEND_FCS(1'b0)) dut0 (
    .clk(clk), .res(res), .abort(abort0), .s_data(s_data0), .s_valid(s_valid0),
    .s_last(s_last0), .s_ready(s_ready0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
    .tx_fcs(tx_fcs0), .tx_eof(tx_eof0), .busy(busy0), .crc_out(crc_out0),
    .crc_done(crc_done0));

  int total = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Output monitors
  logic bq[$], fq[$], eq[$];
  int done_cnt = 0, gap_cnt = 0;
  always @(negedge clk) begin
    if (tx_valid) begin bq.push_back(tx_bit); fq.push_back(tx_fcs); eq.push_back(tx_eof); end
    if (crc_done) done_cnt++;
    if (busy && !tx_valid) gap_cnt++;
  end
  logic bq0[$], fq0[$], eq0[$];
  int done0 = 0;
  always @(negedge clk) begin
    if (tx_valid0) begin bq0.push_back(tx_bit0); fq0.push_back(tx_fcs0); eq0.push_back(tx_eof0); end
    if (crc_done0) done0++;
  end

  task automatic clear_mon();
    bq.delete(); fq.delete(); eq.delete(); done_cnt = 0; gap_cnt = 0;
  endtask

  // Reference: byte-at-a-time reflected CRC-32 of the frame.
  function automatic logic [31:0] crc_model(input frame_t d, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ P) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic frame_t str2f(input string s);
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = (i < s.len()) ? s[i] : 8'h00;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input int delay);
    bit ok = 0;
    repeat (delay) @(posedge clk);
    if (delay > 0) #1;
    s_data = b; s_last = last; s_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_frame(input frame_t d, input int n, input dly_t dl);
    for (int i = 0; i < n; i++) send_byte(d[i], (i == n - 1), dl[i]);
  endtask

  task automatic finish_frame(input string tag, input frame_t d, input int n,
                              input int exp_gap, input logic [31:0] exp_crc);
    bit ok = 0;
    logic eb[$];
    int errs = 0, ferrs = 0, eofs = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (!busy) begin ok = 1; break; end
    end
    chk({tag, "_idle"}, ok, 1);
    for (int i = 0; i < n; i++) for (int k = 0; k < 8; k++) eb.push_back(d[i][k]);
    for (int k = 0; k < 32; k++) eb.push_back(exp_crc[k]);
    chk({tag, "_len"}, bq.size(), eb.size());
    for (int i = 0; i < bq.size() && i < eb.size(); i++) begin
      if (bq[i] !== eb[i]) errs++;
      if (fq[i] !== (i >= 8 * n)) ferrs++;
      if (eq[i]) eofs++;
    end
    chk({tag, "_bits"}, errs, 0);
    chk({tag, "_fcsflag"}, ferrs, 0);
    chk({tag, "_eofcnt"}, eofs, 1);
    chk({tag, "_eoflast"}, (eq.size() > 0) ? eq[eq.size() - 1] : 1'b0, 1);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_gap"}, gap_cnt, exp_gap);
    chk({tag, "_crc"}, crc_out, exp_crc);
  endtask

  vec_t vec [0:3];
  dly_t dz, dl;
  frame_t fr;
  logic [31:0] r, prev_crc;
  logic [7:0] a8;
  int n, eg, eofi, fcnt;
  bit ok;

  initial begin
    for (int i = 0; i < 16; i++) dz[i] = 0;
    vec[0].d = str2f(""); vec[0].n = 1; vec[0].crc = 32'hD202EF8D;
    vec[1].d = str2f("a"); vec[1].n = 1; vec[1].crc = 32'hE8B7BE43;
    vec[2].d = str2f("abc"); vec[2].n = 3; vec[2].crc = 32'h352441C2;
    vec[3].d = str2f("123456789"); vec[3].n = 9; vec[3].crc = 32'hCBF43926;

    // Reset state
    #12;
    chk("rst_s_ready", s_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0); chk("rst_crc_out", crc_out, 0);
    chk("rst_crc_done", crc_done, 0);
    @(negedge clk); res = 0;
    @(posedge clk); #1;

    // Known frames, back-to-back
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      send_frame(vec[v].d, vec[v].n, dz);
      finish_frame($sformatf("vec%0d", v), vec[v].d, vec[v].n, 0, vec[v].crc);
    end
    // Receiver-side residue over data+FCS of "123456789"
    r = 32'hFFFFFFFF;
    foreach (bq[i]) r = (r >> 1) ^ ((r[0] ^ bq[i]) ? P : 32'h0);
    chk("residue", r, 32'hDEBB20E3);

    // Same frame with a 5-cycle stall between bytes 3 and 4
    clear_mon();
    dl = dz; dl[3] = 12;
    send_frame(vec[3].d, 9, dl);
    finish_frame("stall", vec[3].d, 9, 5, 32'hCBF43926);

    // Random frames with random stalls
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 6);
      eg = 0;
      for (int i = 0; i < 16; i++) begin
        fr[i] = $urandom_range(0, 255);
        dl[i] = $urandom_range(0, 10);
        if (i > 0 && i < n && dl[i] > 7) eg += dl[i] - 7;
      end
      clear_mon();
      send_frame(fr, n, dl);
      finish_frame($sformatf("rnd%0d", f), fr, n, eg, crc_model(fr, n));
      prev_crc = crc_model(fr, n);
    end

    // Abort inside byte 2, then a full frame must start from INIT
    clear_mon();
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    repeat (3) @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy", busy, 0); chk("abort_tx_valid", tx_valid, 0);
    chk("abort_s_ready", s_ready, 1); chk("abort_keep_crc", crc_out, prev_crc);
    chk("abort_no_done", done_cnt, 0);
    repeat (2) @(posedge clk); #1;
    clear_mon();
    send_frame(vec[3].d, 9, dz);
    finish_frame("post_abort", vec[3].d, 9, 0, 32'hCBF43926);

    // No-FCS instance: single byte 0xA5
    bq0.delete(); fq0.delete(); eq0.delete(); done0 = 0;
    s_data0 = 8'hA5; s_last0 = 1; s_valid0 = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready0) begin ok = 1; break; end
    end
    chk("nofcs_hs", ok, 1);
    @(posedge clk); #1; s_valid0 = 0; s_last0 = 0;
    repeat (12) @(posedge clk); #1;
    chk("nofcs_len", bq0.size(), 8);
    a8 = 0; eofi = -1; fcnt = 0;
    for (int i = 0; i < bq0.size() && i < 8; i++) begin
      a8[i] = bq0[i];
      if (eq0[i]) eofi = i;
      if (fq0[i]) fcnt++;
    end
    chk("nofcs_bits", a8, 8'hA5);
    chk("nofcs_eof_pos", eofi, 7);
    chk("nofcs_fcs", fcnt, 0);
    chk("nofcs_done", done0, 1);
    fr = str2f(""); fr[0] = 8'hA5;
    chk("nofcs_crc", crc_out0, crc_model(fr, 1));

    // Asynchronous reset in the middle of the FCS
    clear_mon();
    send_frame(vec[3].d, 9, dz);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_fcs) begin ok = 1; break; end
    end
    chk("fcs_reached", ok, 1);
    repeat (10) @(negedge clk);
    #3 res = 1;
    #1;
    chk("ares_tx_valid", tx_valid, 0); chk("ares_tx_fcs", tx_fcs, 0);
    chk("ares_tx_bit", tx_bit, 0); chk("ares_busy", busy, 0);
    chk("ares_s_ready", s_ready, 1); chk("ares_crc_out", crc_out, 0);
    chk("ares_crc_done", crc_done, 0);
    @(negedge clk); res = 0;
    repeat (2) @(posedge clk); #1;
    chk("ares_after_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
